imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the byte-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake and writes the payload bytes into instruction memory from address 0 upward. It verifies an 8-bit checksum and holds the pipeline (PC/nPC and stage registers) in reset until a load completes cleanly. It is the write-side counterpart of the fetch path, which only reads instruction memory by PC, and it replaces file-based preloading.

## Interface
- ADDR_WIDTH, 9, instruction-memory byte address width.
- DEPTH, 512, memory size in bytes; maximum accepted payload length.
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  write byte address.
- mem_wdata  output  8  write byte.
- cpu_hold  output  1  holds the core in reset; 0 only in DONE.
- done  output  1  load completed with a good checksum.
- error  output  1  load aborted; sticky until the next start or reset.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit big-endian byte count N), N payload bytes, then one CSUM byte.
- A frame is good when (sum of payload bytes + CSUM) mod 256 == 0.
- A byte transfers on a posedge where in_valid && in_ready.
- States and transitions:
  - IDLE: start goes to LEN_HI.
  - LEN_HI: on transfer, goes to LEN_LO.
  - LEN_LO: on transfer, evaluates the complete 16-bit N. N > DEPTH goes to ERROR. N == 0 goes to CSUM. Otherwise goes to DATA.
  - DATA: each transfer writes the byte at the current address, then increments the address and the byte count. The N-th byte goes to CSUM.
  - CSUM: on transfer, a good checksum goes to DONE; a bad one goes to ERROR.
  - DONE / ERROR: start clears the address, count and sum, clears done/error, and goes to LEN_HI.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in every other state.
- The running sum is 8 bits, wraps mod 256, and is cleared on every accepted start.
- The address counter starts at 0 and reaches at most DEPTH-1. It never wraps, because N ≤ DEPTH is enforced before DATA.
- start while a load is in progress (LEN_HI..CSUM) is ignored.
- start in the same cycle as a stream byte while in IDLE/DONE/ERROR: the byte is not accepted, because in_ready is 0.
- Memory contents are never cleared. After ERROR or a mid-load reset they are partial and undefined for execution, since cpu_hold stays 1.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, state IDLE.
- Outputs are registered; none depends combinationally on the inputs.
- Write latency: a payload byte accepted at edge k produces mem_we=1 with that byte's mem_addr and mem_wdata during the cycle after edge k, for exactly one cycle per byte. Back-to-back transfers give back-to-back writes.
- The CSUM byte accepted at edge k sets done=1 (or error=1) during the cycle after edge k.
- cpu_hold falls in the same cycle done rises.
- The final payload write (mem_we) occurs in the cycle before done rises, so memory is complete before release.
- Idle cycles (in_valid=0) stall the FSM with no change of state.
- Reset asserted at any point forces all reset values immediately, including a write strobe in flight.
- A new start from DONE raises cpu_hold and clears done in the cycle after start.

## Structure
- Package imem_loader_pkg holds:
  - the state enum: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR;
  - DEPTH_DEFAULT = 512;
  - ADDR_WIDTH_DEFAULT = 9.
- Single module with no sub-module. The FSM, address/count counters and checksum accumulator are small enough to keep inline.

## Test plan
- Good load: start, then stream 00 04 11 22 33 44 56 → writes (0,11)(1,22)(2,33)(3,44) on consecutive cycles; done=1, error=0, cpu_hold=0 one cycle after the 56 byte.
- Bad checksum: the same frame with CSUM 57 → the four writes still occur; error=1, done=0, cpu_hold stays 1. A following start with the good frame → done=1.
- Oversize length: stream 02 01 (N=513) → ERROR after LEN_LO, no mem_we ever, in_ready=0 afterwards. 02 00 (N=512) with a full payload → last write at address 511, no wrap.
- Zero length with gaps: stream 00 00 00 with in_valid deasserted for 3 cycles between bytes → no writes; done=1 after the 00 checksum byte.
- Reset mid-load: assert reset after 2 of 4 payload bytes → all outputs at reset values immediately; no further mem_we; start plus a full frame then loads correctly from address 0.
- Ignored start: pulse start during DATA → no restart, and the address sequence continues uninterrupted.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and default sizing for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    localparam int DEPTH_DEFAULT      = 512;
    localparam int ADDR_WIDTH_DEFAULT = 9;
    localparam int LEN_W              = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    // slave: the loader itself; master: the stream source / memory side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Receives a framed byte stream, writes the payload into instruction memory
// from address 0 and releases the core only after a good 8-bit checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DEPTH      = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [7:0]            sum_q, sum_d;

    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  xfer;
    logic [LEN_W-1:0]      frame_len;
    logic [7:0]            sum_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            len_q       <= '0;
            len_hi_q    <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            len_hi_q    <= len_hi_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        len_d       = len_q;
        len_hi_d    = len_hi_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // in_ready is registered from the state, so a transfer needs no input path to outputs.
        xfer      = bus.in_valid && in_ready_q;
        frame_len = {len_hi_q, bus.in_data};
        sum_next  = sum_q + bus.in_data;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_HI;
                    addr_d  = '0;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d = frame_len;
                    if (frame_len > LEN_W'(DEPTH))  state_d = ERROR;
                    else if (frame_len == '0)       state_d = CSUM;
                    else                            state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.in_data;
                    sum_d       = sum_next;
                    count_d     = count_q + 1'b1;
                    // Hold the address on the last byte so it tops out at DEPTH-1.
                    if (count_d == len_q) state_d = CSUM;
                    else                  addr_d  = addr_q + 1'b1;
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (sum_next == 8'h00) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == DATA)   || (state_d == CSUM);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
        cpu_hold_d = (state_d != DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed frames, writes and status checked by a monitor.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = ADDR_WIDTH_DEFAULT;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, done, error;

    imem_loader_if #(.ADDR_WIDTH(AW)) sif ();

    imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH_DEFAULT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (sif),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } sexp_t;

    localparam int S_DONE  = 0;
    localparam int S_ERR   = 1;
    localparam int S_HOLD  = 2;
    localparam int S_RDY   = 3;
    localparam int S_WE    = 4;
    localparam int S_ADDR  = 5;
    localparam int S_WDATA = 6;

    logic [AW+7:0] wr_q[$];
    sexp_t         st_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          fin_req  = 1'b0;
    logic          fin_done = 1'b0;

    function automatic logic [31:0] sel(input int s);
        case (s)
            S_DONE:  return {31'b0, done};
            S_ERR:   return {31'b0, error};
            S_HOLD:  return {31'b0, cpu_hold};
            S_RDY:   return {31'b0, sif.in_ready};
            S_WE:    return {31'b0, sif.mem_we};
            S_ADDR:  return 32'(sif.mem_addr);
            default: return 32'(sif.mem_wdata);
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes write and status expectations on the falling edge.
    initial begin
        logic [AW+7:0] e;
        sexp_t         s;
        forever begin
            @(negedge clk);
            if (sif.mem_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%02h expected no write",
                             sif.mem_addr, sif.mem_wdata);
                end else begin
                    e = wr_q.pop_front();
                    cmp("mem_write", {sif.mem_addr, sif.mem_wdata}, 32'(e));
                end
            end
            while (st_q.size() > 0) begin
                s = st_q.pop_front();
                cmp(s.name, sel(s.sig), s.val);
            end
            if (fin_req && !fin_done) begin
                cmp("writes_drained", 32'(wr_q.size()), 32'd0);
                fin_done = 1'b1;
            end
        end
    end

    task automatic expect_st(input string name, input int sig, input logic [31:0] val);
        sexp_t s;
        s.name = name;
        s.sig  = sig;
        s.val  = val;
        st_q.push_back(s);
    endtask

    task automatic expect_wr(input int addr, input logic [7:0] data);
        wr_q.push_back({AW'(addr), data});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic st = 1'b0);
        int waited;
        waited      = 0;
        start       = st;
        sif.in_data = b;
        sif.in_valid = 1'b1;
        while (!sif.in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 40) expect_st("send_ready_timeout", S_RDY, 32'd1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic send_frame4(input logic [7:0] csum);
        logic [7:0] pl [4];
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        send(8'h00);
        send(8'h04);
        for (int i = 0; i < 4; i++) begin
            expect_wr(i, pl[i]);
            send(pl[i]);
        end
        send(csum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        sif.in_data  = 8'h00;
        sif.in_valid = 1'b0;
        idle(2);
        expect_st("rst_in_ready", S_RDY,   0);
        expect_st("rst_mem_we",   S_WE,    0);
        expect_st("rst_mem_addr", S_ADDR,  0);
        expect_st("rst_wdata",    S_WDATA, 0);
        expect_st("rst_cpu_hold", S_HOLD,  1);
        expect_st("rst_done",     S_DONE,  0);
        expect_st("rst_error",    S_ERR,   0);
        idle(1);
        reset = 1'b0;
        idle(2);
        expect_st("idle_ready", S_RDY, 0);

        // Good load
        pulse_start();
        expect_st("lenhi_ready", S_RDY, 1);
        send_frame4(8'h56);
        expect_st("good_done",  S_DONE, 1);
        expect_st("good_error", S_ERR,  0);
        expect_st("good_hold",  S_HOLD, 0);
        expect_st("good_ready", S_RDY,  0);
        idle(2);

        // Restart from DONE, then bad checksum, then recovery
        pulse_start();
        expect_st("restart_hold", S_HOLD, 1);
        expect_st("restart_done", S_DONE, 0);
        send_frame4(8'h57);
        expect_st("bad_error", S_ERR,  1);
        expect_st("bad_done",  S_DONE, 0);
        expect_st("bad_hold",  S_HOLD, 1);
        idle(2);
        pulse_start();
        expect_st("err_cleared", S_ERR, 0);
        send_frame4(8'h56);
        expect_st("recover_done", S_DONE, 1);
        idle(2);

        // Oversize length 513
        pulse_start();
        send(8'h02);
        send(8'h01);
        expect_st("over_error", S_ERR,  1);
        expect_st("over_ready", S_RDY,  0);
        expect_st("over_done",  S_DONE, 0);
        idle(3);
        expect_st("over_ready_later", S_RDY, 0);

        // Maximum length 512; payload i mod 256 sums to 0 mod 256
        pulse_start();
        send(8'h02);
        send(8'h00);
        for (int i = 0; i < 512; i++) begin
            expect_wr(i, 8'(i));
            send(8'(i));
        end
        send(8'h00);
        expect_st("max_done",      S_DONE, 1);
        expect_st("max_last_addr", S_ADDR, 511);
        expect_st("max_error",     S_ERR,  0);
        idle(2);

        // Zero length with stalls between bytes
        pulse_start();
        send(8'h00);
        idle(3);
        expect_st("gap_ready", S_RDY,  1);
        expect_st("gap_done",  S_DONE, 0);
        send(8'h00);
        idle(3);
        send(8'h00);
        expect_st("zero_done", S_DONE, 1);
        expect_st("zero_hold", S_HOLD, 0);
        idle(2);

        // Reset after two payload bytes; second write is killed in flight
        pulse_start();
        send(8'h00);
        send(8'h04);
        expect_wr(0, 8'h11);
        send(8'h11);
        send(8'h22);
        reset = 1'b1;
        #1;
        expect_st("mid_rst_we",    S_WE,   0);
        expect_st("mid_rst_addr",  S_ADDR, 0);
        expect_st("mid_rst_hold",  S_HOLD, 1);
        expect_st("mid_rst_ready", S_RDY,  0);
        expect_st("mid_rst_done",  S_DONE, 0);
        idle(1);
        reset = 1'b0;
        idle(2);
        pulse_start();
        send_frame4(8'h56);
        expect_st("after_rst_done", S_DONE, 1);
        idle(2);

        // Start pulsed during DATA is ignored
        pulse_start();
        send(8'h00);
        send(8'h04);
        expect_wr(0, 8'h11);
        send(8'h11);
        expect_wr(1, 8'h22);
        send(8'h22, 1'b1);
        expect_st("ign_ready", S_RDY, 1);
        expect_wr(2, 8'h33);
        send(8'h33);
        expect_wr(3, 8'h44);
        send(8'h44);
        send(8'h56);
        expect_st("ign_done", S_DONE, 1);
        idle(3);

        fin_req = 1'b1;
        wait (fin_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
